// File: rtl/hs_pkg.sv
// Shared HS lane definitions: state encodings common to the
// transmit and receive control units, plus the default sync byte.
package hs_pkg;

    typedef enum logic [2:0] {
        HS_IDLE  = 3'd0,
        HS_ZERO  = 3'd1,
        HS_SYNC  = 3'd2,
        HS_DATA  = 3'd3,
        HS_TRAIL = 3'd4,
        HS_EOT   = 3'd5
    } hs_state_e;

    localparam logic [7:0] HS_SYNC_PATTERN = 8'hB8;

endpackage

// File: rtl/hs_tx_serializer.sv
// 8-bit parallel-in serial-out shifter for the HS transmit lane.
// Load wins over shift; the lane bit is always the LSB.
module hs_tx_serializer (
    input  logic       RxDDRClkHS,
    input  logic       RST,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    output logic       sout
);

    logic [7:0] sreg;

    always_ff @(posedge RxDDRClkHS or negedge RST) begin
        if (!RST) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_data;
        end else if (shift) begin
            sreg <= {1'b0, sreg[7:1]};
        end
    end

    assign sout = sreg[0];

endmodule

// File: rtl/hs_tx_ctrl.sv
// D-PHY HS transmit controller: leader, sync, LSB-first payload, trail, EOT.
// Optional HS_TX_BYTE_CNT_EN adds the TxByteCountHS accepted-byte counter.
module hs_tx_ctrl
    import hs_pkg::*;
#(
    parameter int         HS_ZERO_BITS = 16,
    parameter int         TRAIL_BITS   = 16,
    parameter logic [7:0] SYNC_PATTERN = HS_SYNC_PATTERN
) (
    input  logic        RxDDRClkHS,
    input  logic        RST,
    input  logic        TxRequestHS,
    input  logic [7:0]  TxDataHS,
    output logic        TxReadyHS,
    output logic        HS_TX_DATA,
    output logic        HS_TX_EN,
`ifdef HS_TX_BYTE_CNT_EN
    output logic        TxActiveHS,
    output logic [15:0] TxByteCountHS
`else
    output logic        TxActiveHS
`endif
);

    localparam int LEN_MAX = (HS_ZERO_BITS > TRAIL_BITS) ? HS_ZERO_BITS : TRAIL_BITS;
    localparam int LW      = $clog2(LEN_MAX + 1);

    localparam logic [LW-1:0] ZERO_LAST  = LW'(HS_ZERO_BITS - 1);
    localparam logic [LW-1:0] TRAIL_LAST = LW'(TRAIL_BITS - 1);
    localparam logic [LW-1:0] LEN_ONE    = LW'(1);

    hs_state_e   state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic        trail_q, trail_d;
    logic        data_d, en_d, ready_d, active_d;
    logic        ld, sh, sout;
    logic [7:0]  ld_data;

    hs_tx_serializer u_ser (
        .RxDDRClkHS (RxDDRClkHS),
        .RST        (RST),
        .load       (ld),
        .load_data  (ld_data),
        .shift      (sh),
        .sout       (sout)
    );

    // Lane outputs are registered, so they trail the internal state by one
    // cycle; the only exception is bit 0 of a newly accepted byte, which is
    // taken straight from TxDataHS so it lands on the lane right after the
    // accepting edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        trail_d  = trail_q;
        data_d   = 1'b0;
        en_d     = 1'b0;
        ready_d  = 1'b0;
        active_d = (state_q != HS_IDLE);
        ld       = 1'b0;
        ld_data  = SYNC_PATTERN;
        sh       = 1'b0;
        unique case (state_q)
            HS_IDLE: begin
                if (TxRequestHS) begin
                    state_d = HS_ZERO;
                    cnt_d   = '0;
                    bit_d   = '0;
                    trail_d = 1'b0;
                end
            end
            HS_ZERO: begin
                en_d = 1'b1;
                if (cnt_q == ZERO_LAST) begin
                    state_d = HS_SYNC;
                    ld      = 1'b1;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + LEN_ONE;
                end
            end
            HS_SYNC, HS_DATA: begin
                en_d = 1'b1;
                if (TxReadyHS) begin
                    if (TxRequestHS) begin
                        state_d = HS_DATA;
                        ld      = 1'b1;
                        ld_data = {1'b0, TxDataHS[7:1]};
                        data_d  = TxDataHS[0];
                        bit_d   = 3'd1;
                    end else begin
                        trail_d = ~HS_TX_DATA;
                        data_d  = ~HS_TX_DATA;
                        cnt_d   = LEN_ONE;
                        state_d = (TRAIL_BITS == 1) ? HS_EOT : HS_TRAIL;
                    end
                end else begin
                    data_d  = sout;
                    sh      = 1'b1;
                    bit_d   = bit_q + 3'd1;
                    ready_d = (bit_q == 3'd7);
                end
            end
            HS_TRAIL: begin
                en_d   = 1'b1;
                data_d = trail_q;
                if (cnt_q == TRAIL_LAST) begin
                    state_d = HS_EOT;
                end else begin
                    cnt_d = cnt_q + LEN_ONE;
                end
            end
            HS_EOT: begin
                state_d = HS_IDLE;
            end
            default: begin
                state_d = HS_IDLE;
            end
        endcase
    end

    always_ff @(posedge RxDDRClkHS or negedge RST) begin
        if (!RST) begin
            state_q    <= HS_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            trail_q    <= 1'b0;
            HS_TX_DATA <= 1'b0;
            HS_TX_EN   <= 1'b0;
            TxReadyHS  <= 1'b0;
            TxActiveHS <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            trail_q    <= trail_d;
            HS_TX_DATA <= data_d;
            HS_TX_EN   <= en_d;
            TxReadyHS  <= ready_d;
            TxActiveHS <= active_d;
        end
    end

`ifdef HS_TX_BYTE_CNT_EN
    logic [15:0] byte_cnt_q;
    logic        byte_clr;
    logic        byte_inc;

    assign byte_clr = (state_q == HS_IDLE) && TxRequestHS;
    assign byte_inc = ((state_q == HS_SYNC) || (state_q == HS_DATA))
                      && TxReadyHS && TxRequestHS;

    always_ff @(posedge RxDDRClkHS or negedge RST) begin
        if (!RST) begin
            byte_cnt_q <= '0;
        end else if (byte_clr) begin
            byte_cnt_q <= '0;
        end else if (byte_inc && (byte_cnt_q != 16'hFFFF)) begin
            byte_cnt_q <= byte_cnt_q + 16'd1;
        end
    end

    assign TxByteCountHS = byte_cnt_q;
`endif

endmodule
